// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, parameter legality helpers and status bundle for sync_fifo_stat
package fifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // The extra pointer bit is the wrap bit that separates full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_ok(input int af, input int depth);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_ok(input int ae, input int depth);
        return (ae >= 0) && (ae <= depth - 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - simple dual-port FIFO storage; FIFO_FWFT_EN selects an asynchronous read port
module fifo_dpram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, rd_en, rst};
    assign rd_data   = mem[rd_addr];
`else
    // Read register holds its last word between accepted reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_stat.sv
// rtl/sync_fifo_stat.sv - synchronous FIFO with occupancy, thresholds and sticky errors; FIFO_FWFT_EN selects first-word-fall-through
module sync_fifo_stat
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        r_en,
    input  logic                        clr_err,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [ptr_w(DEPTH)-1:0]     count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int PTR_W  = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] AF_T = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $fatal(1, "sync_fifo_stat: DEPTH must be a power of two >= 2");
    end
    if (!af_ok(AF_THRESH, DEPTH)) begin : g_bad_af
        $fatal(1, "sync_fifo_stat: AF_THRESH out of range 1..DEPTH");
    end
    if (!ae_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
        $fatal(1, "sync_fifo_stat: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] occ;
    logic             full_i;
    logic             empty_i;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_q;
    logic             unf_q;
    fifo_status_t     st;

    assign occ     = w_ptr - r_ptr;
    assign full_i  = (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]) && (w_ptr[ADDR_W] != r_ptr[ADDR_W]);
    assign empty_i = (w_ptr == r_ptr);
    assign wr_acc  = w_en && !full_i;
    assign rd_acc  = r_en && !empty_i;

    assign st = '{full:         full_i,
                  empty:        empty_i,
                  almost_full:  (occ >= AF_T),
                  almost_empty: (occ <= AE_T),
                  overflow:     ovf_q,
                  underflow:    unf_q};

    // A fresh error outranks a coincident clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
            ovf_q <= (w_en && full_i) || (ovf_q && !clr_err);
            unf_q <= (r_en && empty_i) || (unf_q && !clr_err);
        end
    end

    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (w_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (r_ptr[ADDR_W-1:0]),
        .rd_data (data_out)
    );

`ifdef FIFO_FWFT_EN
    assign rd_valid = !empty_i;
`else
    logic rv_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rv_q <= 1'b0;
        end else begin
            rv_q <= rd_acc;
        end
    end
    assign rd_valid = rv_q;
`endif

    assign full         = st.full;
    assign empty        = st.empty;
    assign almost_full  = st.almost_full;
    assign almost_empty = st.almost_empty;
    assign overflow     = st.overflow;
    assign underflow    = st.underflow;
    assign count        = occ;

endmodule

// File: tb/tb_sync_fifo_stat.sv
// tb/tb_sync_fifo_stat.sv - self-checking bench for sync_fifo_stat against a queue-based reference model
module tb_sync_fifo_stat;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic [7:0] data_in;
    logic       r_en;
    logic       clr_err;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    sync_fifo_stat #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .AF_THRESH  (6),
        .AE_THRESH  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic       m_rv  = 1'b0;
    logic [7:0] m_dout = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == 8));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
        chk("rd_valid", 32'(rd_valid), 32'(n != 0));
        if (n != 0) chk("data_out_head", 32'(data_out), 32'(q[0]));
`else
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    // One clock of stimulus; the model applies the FIFO rules to pre-edge occupancy.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit was_full, was_empty;
        @(negedge clk);
        rst = 1'b1; w_en = w; data_in = d; r_en = r; clr_err = c;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        m_rv = 1'b0;
        if (r && !was_empty) begin
            m_dout = q.pop_front();
            m_rv   = 1'b1;
        end
        if (w && !was_full) q.push_back(d);
        m_ovf = (w && was_full) || (m_ovf && !c);
        m_unf = (r && was_empty) || (m_unf && !c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic rst_cyc(input logic w, input logic r);
        @(negedge clk);
        rst = 1'b0; w_en = w; data_in = 8'h5A; r_en = r; clr_err = 1'b0;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0; m_dout = 8'h00;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b0; w_en = 1'b0; data_in = 8'h00; r_en = 1'b0; clr_err = 1'b0;
        @(posedge clk);
        rst_cyc(1'b0, 1'b0);

        // Fill with 0x01..0x08, then a dropped ninth write
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 2) chk("ae_drop_at_2", 32'(almost_empty), 32'd0);
            if (i == 6) chk("af_rise_at_6", 32'(almost_full), 32'd1);
        end
        chk("full_after_fill", 32'(full), 32'd1);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("overflow_9th_write", 32'(overflow), 32'd1);
        chk("count_after_drop", 32'(count), 32'd8);

        // Drain in order, then a ninth read
        for (int i = 1; i <= 8; i++) begin
`ifndef FIFO_FWFT_EN
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_order", 32'(data_out), 32'(i));
`else
            chk("drain_order", 32'(data_out), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
`endif
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("underflow_9th_read", 32'(underflow), 32'd1);
`ifndef FIFO_FWFT_EN
        chk("data_out_holds_08", 32'(data_out), 32'h08);
`endif
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_both", 32'({overflow, underflow}), 32'd0);

        // Wrap-around at steady occupancy 3
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
            chk("wrap_count_3", 32'(count), 32'd3);
        end

        // Both requests at full: only the read lands
        while (q.size() < 8) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_wr_rd_count", 32'(count), 32'd7);
        chk("full_wr_rd_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b0, 1'b1);
        chk("clr_vs_new_ovf", 32'(overflow), 32'd1);

        // Both requests at empty: only the write lands
        while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("empty_wr_rd_count", 32'(count), 32'd1);
        chk("empty_wr_rd_unf", 32'(underflow), 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) rst_cyc(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
            else cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                     $urandom_range(0, 99) < 5);
        end

        // Mid-operation reset at count 5
        rst_cyc(1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h06, 1'b0, 1'b0);
        chk("pre_reset_count5", 32'(count), 32'd5);
        rst_cyc(1'b1, 1'b1);
        chk("mid_reset_count", 32'(count), 32'd0);
        chk("mid_reset_empty", 32'(empty), 32'd1);
        chk("mid_reset_flags", 32'({overflow, underflow, rd_valid, full, almost_full}), 32'd0);
`ifndef FIFO_FWFT_EN
        chk("mid_reset_data_out", 32'(data_out), 32'd0);
`endif

        // Head word appearance after a write into an empty FIFO
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        chk("fwft_head_visible", 32'(data_out), 32'h01);
        chk("fwft_rd_valid", 32'(rd_valid), 32'd1);
`else
        chk("std_no_read_no_valid", 32'(rd_valid), 32'd0);
`endif

        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_stat.md
# sync_fifo_stat

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a read-valid strobe. It is the next-generation byte/word buffer of the UART-to-DDR data path, sitting between the UART RX byte stream and the AXI write-burst builder. Burst logic uses the thresholds to decide when to launch transfers.

## Interface
- DATA_WIDTH, 8: width of a FIFO word.
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request.
- clr_err  in  1  clears overflow/underflow on the next edge.
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out holds a freshly read word (mode dependent, see Configuration).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Pointers w_ptr, r_ptr are ADDR_W+1 bits (ADDR_W = $clog2(DEPTH)); the low ADDR_W bits address memory, and the MSB is the wrap bit. Both wrap modulo 2·DEPTH naturally.
- count = w_ptr − r_ptr, modulo 2^(ADDR_W+1).
- full = (low bits equal) && (MSBs differ); empty = (pointers equal).
- A write is accepted iff w_en && !full; it stores data_in at w_addr and increments w_ptr.
- A read is accepted iff r_en && !empty; it increments r_ptr.
- full/empty are evaluated on pre-edge state.
- Simultaneous read and write, not full and not empty: both accepted, count unchanged.
- w_en while full: write dropped even if a read is accepted the same cycle; overflow sets.
- r_en while empty: read dropped even if a write is accepted the same cycle; underflow sets.
- Sticky flags: once set, a flag holds until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Reset, including mid-operation, takes effect on the next edge with these values:
  - pointers 0, count 0
  - empty=1, full=0, almost_full=0, almost_empty=1
  - overflow=0, underflow=0, rd_valid=0, data_out=0
- Memory contents are not reset.

## Timing
- All status outputs are combinational from registered pointers. They reflect an accepted write or read in the cycle after its edge.
- Write-to-read: a word written at edge N can be accepted by a read at edge N+1 at the earliest.
- Standard mode read latency is 1 cycle.
  - data_out and rd_valid update on the edge that accepts the read.
  - rd_valid is a one-cycle pulse.
  - data_out holds its last value when no read is accepted.
- Error flags are visible the cycle after the offending request.

## Configuration
- FIFO_FWFT_EN defined (first-word-fall-through mode):
  - data_out = mem[r_addr] combinationally.
  - rd_valid = !empty.
  - r_en acts as an acknowledge that pops the head word.
  - Head word is visible the cycle after the edge that wrote it into an empty FIFO.
  - data_out is undefined while empty.
- FIFO_FWFT_EN undefined (standard mode):
  - Registered data_out with 1-cycle latency and pulsed rd_valid, as in Timing.
- All other behaviour is identical in both modes.

## Structure
- Package fifo_pkg:
  - clog2-based ADDR_W helper and pointer-width constant.
  - Parameter legality checks (DEPTH power of two, threshold ranges), elaborated as fatal errors.
  - A status struct/typedef bundling full, empty, almost_full, almost_empty, overflow and underflow.
- Sub-module fifo_dpram: simple dual-port memory with
  - one synchronous write port;
  - read port registered in standard mode, asynchronous in FWFT mode, selected by the same macro.
- Pointer, flag and error logic stay in sync_fifo_stat.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1.
- Reset then fill: write 0x01..0x08.
  - almost_empty drops at count=2.
  - almost_full rises at count=6.
  - full=1, count=8 after the 8th write.
  - A 9th write of 0xFF is dropped and sets overflow.
- Drain after fill: 8 reads return 0x01..0x08 in order; standard mode returns each one cycle after its accepted read.
  - empty=1, count=0 at the end.
  - A 9th read sets underflow; data_out keeps 0x08.
- Wrap-around: repeat 20 cycles of write+read at count=3.
  - count stays 3.
  - Data order is preserved across the pointer MSB toggling twice.
- Simultaneous read/write at boundaries:
  - Full with w_en+r_en: only the read is accepted; count 8→7; overflow=1.
  - Empty with w_en+r_en: only the write is accepted; count 0→1; underflow=1.
- Sticky clear: with overflow=1, pulse clr_err → overflow=0.
  - clr_err coincident with a new overflow keeps overflow=1.
- Mid-operation reset at count=5: after one edge, count=0, empty=1, all flags and data_out cleared.
  - Repeat both checks with FIFO_FWFT_EN defined: rd_valid=!empty, head 0x01 visible with no r_en.
